// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the Sudoku solution streamer.
// Grid storage is box-major: grid[box][inner], inner cells row-major within the box.
package sudoku_pkg;

    localparam int GRID_DIM = 9;
    localparam int BOX_DIM  = 3;
    localparam int CELLS    = GRID_DIM * GRID_DIM;

    localparam logic [7:0] ASCII_ONE = 8'h31;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;

    // Candidate mask for one cell: bit k set means digit k+1 is possible.
    typedef logic [GRID_DIM-1:0] cell_t;

    // Full 9x9 grid, indexed [box][inner].
    typedef cell_t [GRID_DIM-1:0][GRID_DIM-1:0] grid_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        EOL_CR,
        EOL_LF,
        DONE
    } state_t;

    // ASCII digit for a one-hot mask; for other masks the lowest set bit wins,
    // so callers must qualify the result with a population count.
    function automatic logic [7:0] onehot_to_ascii(input cell_t mask);
        logic [7:0] ch;
        ch = 8'h00;
        for (int k = GRID_DIM - 1; k >= 0; k--) begin
            if (mask[k]) ch = ASCII_ONE + 8'(k);
        end
        return ch;
    endfunction

endpackage

// File: rtl/cell_to_ascii.sv
// Combinational cell encoder: candidate mask -> ASCII byte plus ambiguity flag.
module cell_to_ascii
    import sudoku_pkg::*;
#(
    parameter logic [7:0] CHAR_UNSOLVED = 8'h2E,
    parameter logic [7:0] CHAR_AMBIG    = 8'h3F
) (
    input  logic [8:0] cell_i,
    output logic [7:0] char_o,
    output logic       ambig_o
);

    // Classify the mask by its population count and pick the output byte.
    always_comb begin
        ambig_o = 1'b0;
        char_o  = CHAR_UNSOLVED;
        if ($countones(cell_i) == 1) begin
            char_o = onehot_to_ascii(cell_i);
        end else if ($countones(cell_i) > 1) begin
            char_o  = CHAR_AMBIG;
            ambig_o = 1'b1;
        end
    end

endmodule

// File: rtl/solution_streamer.sv
// Streams a solved (or partially solved) Sudoku grid as ASCII over a
// valid/ready handshake, row-major, one character per cycle.
// Optional feature macro: SOLUTION_STREAMER_CRLF_EN appends CR LF after each row.
module solution_streamer
    import sudoku_pkg::*;
#(
    parameter logic [7:0] CHAR_UNSOLVED = 8'h2E,
    parameter logic [7:0] CHAR_AMBIG    = 8'h3F
) (
    input  logic         i_Clk,
    input  logic         i_Rst_L,
    input  logic [728:0] i_Grid,
    input  logic         i_Complete,
    output logic [7:0]   o_Data,
    output logic         o_Valid,
    input  logic         i_Ready,
    output logic         o_Busy,
    output logic         o_Done,
    output logic         o_Error
);

    localparam logic [3:0] LAST_IDX = 4'(GRID_DIM - 1);

    state_t     state_q, state_d;
    logic [3:0] row_q, row_d;
    logic [3:0] col_q, col_d;
    logic       error_q, error_d;
    logic       complete_q;
    grid_t      grid_q;

    logic       start;
    logic [3:0] box_sel;
    logic [3:0] inner_sel;
    cell_t      sel_cell;
    logic [7:0] cell_char;
    logic       cell_ambig;

    assign start   = (state_q == IDLE) && i_Complete && !complete_q;
    assign o_Error = error_q;

    // Control state, counters, sticky error and the completion edge register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            error_q    <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            error_q    <= error_d;
            complete_q <= i_Complete;
        end
    end

    // Snapshot of the solver grid taken at the start of a readout.
    // NOTE: the grid snapshot has no reset; it is always overwritten at start before it is read.
    always_ff @(posedge i_Clk) begin
        if (start) grid_q <= i_Grid;
    end

    // Map the row-major position to the box-major storage index.
    always_comb begin
        box_sel   = 4'((int'(row_q) / BOX_DIM) * BOX_DIM + int'(col_q) / BOX_DIM);
        inner_sel = 4'((int'(row_q) % BOX_DIM) * BOX_DIM + int'(col_q) % BOX_DIM);
        sel_cell  = grid_q[box_sel][inner_sel];
    end

    cell_to_ascii #(
        .CHAR_UNSOLVED (CHAR_UNSOLVED),
        .CHAR_AMBIG    (CHAR_AMBIG)
    ) u_cell_to_ascii (
        .cell_i  (sel_cell),
        .char_o  (cell_char),
        .ambig_o (cell_ambig)
    );

    // Next-state and output decode; counters advance only on acceptance.
    // NOTE: every output of this block gets a default first so no latches are inferred.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        error_d = error_q;
        o_Valid = 1'b0;
        o_Busy  = 1'b1;
        o_Done  = 1'b0;
        o_Data  = 8'h00;

        case (state_q)
            IDLE: begin
                o_Busy = 1'b0;
                if (start) begin
                    error_d = 1'b0;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = SEND;
                end
            end

            SEND: begin
                o_Valid = 1'b1;
                o_Data  = cell_char;
                if (i_Ready) begin
                    if (cell_ambig) error_d = 1'b1;
                    if (col_q == LAST_IDX) begin
                        col_d = '0;
`ifdef SOLUTION_STREAMER_CRLF_EN
                        state_d = EOL_CR;
`else
                        if (row_q == LAST_IDX) state_d = DONE;
                        else                   row_d   = row_q + 4'd1;
`endif
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end

            EOL_CR: begin
                o_Valid = 1'b1;
                o_Data  = ASCII_CR;
                if (i_Ready) state_d = EOL_LF;
            end

            EOL_LF: begin
                o_Valid = 1'b1;
                o_Data  = ASCII_LF;
                if (i_Ready) begin
                    if (row_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + 4'd1;
                        state_d = SEND;
                    end
                end
            end

            DONE: begin
                o_Done  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
